// File: rtl/stream_fixed_latency_adapter_pkg.sv
// Shared helpers for the fixed-latency stream adapter.
package stream_fixed_latency_adapter_pkg;

  // Circular-buffer pointer advance; depth need not be a power of two.
  function automatic int unsigned wrap_inc(input int unsigned ptr, input int unsigned depth);
    return (ptr + 32'd1 >= depth) ? 32'd0 : ptr + 32'd1;
  endfunction

endpackage

// File: rtl/stream_fixed_latency_adapter_shift_reg.sv
// Fixed-depth delay line with asynchronous active-low reset; Depth=0 is a wire.
module shift_reg #(
  parameter int dtype_w = 1,
  parameter int Depth   = 1
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic [dtype_w-1:0] d_i,
  output logic [dtype_w-1:0] d_o
);

  if (Depth == 0) begin : g_pass
    logic w_unused;
    assign w_unused = clk_i ^ rst_ni;
    assign d_o      = d_i;
  end else begin : g_reg
    logic [dtype_w-1:0] r_stage [Depth];

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        for (int i = 0; i < Depth; i++) r_stage[i] <= '0;
      end else begin
        r_stage[0] <= d_i;
        for (int i = 1; i < Depth; i++) r_stage[i] <= r_stage[i-1];
      end
    end

    assign d_o = r_stage[Depth-1];
  end

endmodule

// File: rtl/stream_fixed_latency_adapter.sv
// Credit-gated valid/ready wrapper around a fixed-latency, non-stallable unit.
module stream_fixed_latency_adapter
  import stream_fixed_latency_adapter_pkg::*;
#(
  parameter int DataWidth = 8,
  parameter int Latency   = 2,
  parameter int FifoDepth = 3
) (
  input  logic                             clk_i,
  input  logic                             rst_ni,
  input  logic                             valid_i,
  output logic                             ready_o,
  input  logic [DataWidth-1:0]             data_i,
  output logic                             pipe_valid_o,
  output logic [DataWidth-1:0]             pipe_data_o,
  input  logic [DataWidth-1:0]             pipe_data_i,
  output logic                             valid_o,
  input  logic                             ready_i,
  output logic [DataWidth-1:0]             data_o,
  output logic [$clog2(FifoDepth+1)-1:0]   credits_o
);

  localparam int CntW = $clog2(FifoDepth + 1);
  localparam int PtrW = (FifoDepth > 1) ? $clog2(FifoDepth) : 1;

  if (FifoDepth < 1) begin : g_bad_depth
    $error("FifoDepth must be at least 1");
  end

  logic [CntW-1:0]      r_cred;
  logic [CntW-1:0]      r_count;
  logic [CntW-1:0]      r_infl;
  logic [PtrW-1:0]      r_wr_ptr;
  logic [PtrW-1:0]      r_rd_ptr;
  logic [DataWidth-1:0] r_mem [FifoDepth];
  logic [DataWidth-1:0] w_head;
  logic                 w_accept;
  logic                 w_tok_out;
  logic                 w_push;
  logic                 w_pop;

  assign ready_o      = (r_cred != '0);
  assign w_accept     = valid_i && ready_o;
  assign pipe_valid_o = w_accept;
  assign pipe_data_o  = data_i;

  shift_reg #(
    .dtype_w (1),
    .Depth   (Latency)
  ) u_tok_line (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .d_i    (w_accept),
    .d_o    (w_tok_out)
  );

  assign w_push    = w_tok_out;
  assign valid_o   = (r_count != '0);
  assign w_pop     = valid_o && ready_i;
  assign data_o    = w_head;
  assign credits_o = r_cred;

  always_comb begin
    w_head = '0;
    for (int i = 0; i < FifoDepth; i++) begin
      if (r_rd_ptr == PtrW'(i)) w_head = r_mem[i];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < FifoDepth; i++) r_mem[i] <= '0;
    end else if (w_push) begin
      for (int i = 0; i < FifoDepth; i++) begin
        if (r_wr_ptr == PtrW'(i)) r_mem[i] <= pipe_data_i;
      end
    end
  end

  // A credit frees only the cycle after its pop, so sustained one-per-cycle
  // flow needs FifoDepth >= Latency+2; shallower buffers run at a fraction.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_cred   <= CntW'(FifoDepth);
      r_count  <= '0;
      r_infl   <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      case ({w_accept, w_pop})
        2'b10:   r_cred <= r_cred - 1'b1;
        2'b01:   r_cred <= r_cred + 1'b1;
        default: r_cred <= r_cred;
      endcase
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      case ({w_accept, w_tok_out})
        2'b10:   r_infl <= r_infl + 1'b1;
        2'b01:   r_infl <= r_infl - 1'b1;
        default: r_infl <= r_infl;
      endcase
      if (w_push) r_wr_ptr <= PtrW'(wrap_inc(32'(r_wr_ptr), FifoDepth));
      if (w_pop)  r_rd_ptr <= PtrW'(wrap_inc(32'(r_rd_ptr), FifoDepth));
    end
  end

  a_credit_invariant: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (32'(r_cred) + 32'(r_count) + 32'(r_infl)) == FifoDepth);

  a_no_push_full: assert property (@(posedge clk_i) disable iff (!rst_ni)
    w_push |-> (32'(r_count) < FifoDepth));

  a_valid_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (valid_o && !ready_i) |=> (valid_o && $stable(data_o)));

endmodule

// File: tb/tb_stream_fixed_latency_adapter.sv
// Directed bench for stream_fixed_latency_adapter across three configurations.
module tb_stream_fixed_latency_adapter;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  int g_cmp = 0;
  int g_err = 0;

  // A: Latency=2, FifoDepth=3
  logic       a_valid_i = 1'b0, a_ready_o, a_pipe_valid_o, a_valid_o, a_ready_i = 1'b0;
  logic [7:0] a_data_i = '0, a_pipe_data_o, a_pipe_data_i, a_data_o;
  logic [1:0] a_credits_o;
  // B: Latency=0, FifoDepth=1
  logic       b_valid_i = 1'b0, b_ready_o, b_pipe_valid_o, b_valid_o, b_ready_i = 1'b0;
  logic [7:0] b_data_i = '0, b_pipe_data_o, b_pipe_data_i, b_data_o;
  logic [0:0] b_credits_o;
  // C: Latency=2, FifoDepth=4
  logic       c_valid_i = 1'b0, c_ready_o, c_pipe_valid_o, c_valid_o, c_ready_i = 1'b0;
  logic [7:0] c_data_i = '0, c_pipe_data_o, c_pipe_data_i, c_data_o;
  logic [2:0] c_credits_o;

  // Unit models: result = request + 100, never reset.
  logic [7:0] ua1, ua2, uc1, uc2;
  always @(posedge clk) begin
    ua1 <= a_pipe_data_o + 8'd100;
    ua2 <= ua1;
    uc1 <= c_pipe_data_o + 8'd100;
    uc2 <= uc1;
  end
  assign a_pipe_data_i = ua2;
  assign c_pipe_data_i = uc2;
  assign b_pipe_data_i = b_pipe_data_o + 8'd100;

  stream_fixed_latency_adapter #(.DataWidth(8), .Latency(2), .FifoDepth(3)) u_dut_a (
    .clk_i(clk), .rst_ni(rst_n), .valid_i(a_valid_i), .ready_o(a_ready_o), .data_i(a_data_i),
    .pipe_valid_o(a_pipe_valid_o), .pipe_data_o(a_pipe_data_o), .pipe_data_i(a_pipe_data_i),
    .valid_o(a_valid_o), .ready_i(a_ready_i), .data_o(a_data_o), .credits_o(a_credits_o));

  stream_fixed_latency_adapter #(.DataWidth(8), .Latency(0), .FifoDepth(1)) u_dut_b (
    .clk_i(clk), .rst_ni(rst_n), .valid_i(b_valid_i), .ready_o(b_ready_o), .data_i(b_data_i),
    .pipe_valid_o(b_pipe_valid_o), .pipe_data_o(b_pipe_data_o), .pipe_data_i(b_pipe_data_i),
    .valid_o(b_valid_o), .ready_i(b_ready_i), .data_o(b_data_o), .credits_o(b_credits_o));

  stream_fixed_latency_adapter #(.DataWidth(8), .Latency(2), .FifoDepth(4)) u_dut_c (
    .clk_i(clk), .rst_ni(rst_n), .valid_i(c_valid_i), .ready_o(c_ready_o), .data_i(c_data_i),
    .pipe_valid_o(c_pipe_valid_o), .pipe_data_o(c_pipe_data_o), .pipe_data_i(c_pipe_data_i),
    .valid_o(c_valid_o), .ready_i(c_ready_i), .data_o(c_data_o), .credits_o(c_credits_o));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #1 rst_n = 1'b0;
    #1;
    g_cmp++; if (a_ready_o !== 1'b1) begin g_err++; $display("FAIL reset_a_ready: got %b want 1", a_ready_o); end
    g_cmp++; if (a_valid_o !== 1'b0) begin g_err++; $display("FAIL reset_a_valid: got %b want 0", a_valid_o); end
    g_cmp++; if (a_credits_o !== 2'd3) begin g_err++; $display("FAIL reset_a_credits: got %0d want 3", a_credits_o); end
    g_cmp++; if (a_data_o !== 8'd0) begin g_err++; $display("FAIL reset_a_data: got %0d want 0", a_data_o); end
    g_cmp++; if (a_pipe_valid_o !== 1'b0) begin g_err++; $display("FAIL reset_a_pipe_valid_idle: got %b want 0", a_pipe_valid_o); end
    g_cmp++; if (b_credits_o !== 1'b1) begin g_err++; $display("FAIL reset_b_credits: got %0d want 1", b_credits_o); end
    g_cmp++; if (c_credits_o !== 3'd4) begin g_err++; $display("FAIL reset_c_credits: got %0d want 4", c_credits_o); end
    a_valid_i = 1'b1;
    a_data_i  = 8'h5A;
    #1;
    g_cmp++; if (a_pipe_valid_o !== 1'b1) begin g_err++; $display("FAIL reset_a_pipe_valid_req: got %b want 1", a_pipe_valid_o); end
    g_cmp++; if (a_pipe_data_o !== 8'h5A) begin g_err++; $display("FAIL reset_a_pipe_data: got %h want 5a", a_pipe_data_o); end
    a_valid_i = 1'b0;
    a_data_i  = '0;
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_full_throughput();
    c_ready_i = 1'b1;
    for (int c = 0; c < 14; c++) begin
      logic exp_v;
      c_valid_i = (c < 10);
      c_data_i  = 8'(c + 1);
      #1;
      exp_v = (c >= 3 && c < 13);
      g_cmp++; if (c_ready_o !== 1'b1) begin g_err++; $display("FAIL thru_ready c%0d: got %b want 1", c, c_ready_o); end
      g_cmp++; if (c_valid_o !== exp_v) begin g_err++; $display("FAIL thru_valid c%0d: got %b want %b", c, c_valid_o, exp_v); end
      if (exp_v) begin
        g_cmp++; if (c_data_o !== 8'(98 + c)) begin g_err++; $display("FAIL thru_data c%0d: got %0d want %0d", c, c_data_o, 98 + c); end
      end
      if (c == 0) begin
        g_cmp++; if (c_pipe_valid_o !== 1'b1) begin g_err++; $display("FAIL thru_pipe_valid: got %b want 1", c_pipe_valid_o); end
      end
      tick();
    end
    c_valid_i = 1'b0;
    #1;
    g_cmp++; if (c_credits_o !== 3'd4) begin g_err++; $display("FAIL thru_credits_end: got %0d want 4", c_credits_o); end
    tick();
  endtask

  // Depth 3 at Latency 2: credits recycle every 4 cycles, so 3 of 4 slots accept.
  task automatic test_depth3_rate();
    logic [15:0] rdy_exp;
    logic [15:0] val_exp;
    int nxt;
    int got;
    rdy_exp = 16'hF777;
    val_exp = 16'hBBB8;
    nxt = 1;
    got = 0;
    a_ready_i = 1'b1;
    for (int c = 0; c < 16; c++) begin
      a_valid_i = (nxt <= 10);
      a_data_i  = 8'(nxt);
      #1;
      g_cmp++; if (a_ready_o !== rdy_exp[c]) begin g_err++; $display("FAIL rate_ready c%0d: got %b want %b", c, a_ready_o, rdy_exp[c]); end
      g_cmp++; if (a_valid_o !== val_exp[c]) begin g_err++; $display("FAIL rate_valid c%0d: got %b want %b", c, a_valid_o, val_exp[c]); end
      if (val_exp[c]) begin
        g_cmp++; if (a_data_o !== 8'(101 + got)) begin g_err++; $display("FAIL rate_data c%0d: got %0d want %0d", c, a_data_o, 101 + got); end
        got++;
      end
      if (rdy_exp[c] && a_valid_i) nxt++;
      tick();
    end
    a_valid_i = 1'b0;
  endtask

  task automatic test_backpressure();
    int acc;
    acc = 0;
    a_ready_i = 1'b0;
    for (int c = 0; c < 5; c++) begin
      a_valid_i = 1'b1;
      a_data_i  = 8'(21 + ((c < 3) ? c : 3));
      #1;
      g_cmp++; if (a_ready_o !== (c < 3)) begin g_err++; $display("FAIL bp_ready c%0d: got %b want %b", c, a_ready_o, (c < 3)); end
      if (c >= 3) begin
        g_cmp++; if (a_credits_o !== 2'd0) begin g_err++; $display("FAIL bp_credits c%0d: got %0d want 0", c, a_credits_o); end
      end
      if (a_pipe_valid_o) acc++;
      tick();
    end
    a_valid_i = 1'b0;
    g_cmp++; if (acc != 3) begin g_err++; $display("FAIL bp_accepted: got %0d want 3", acc); end
    tick();
    a_ready_i = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      g_cmp++; if (a_valid_o !== 1'b1) begin g_err++; $display("FAIL bp_pop_valid k%0d: got %b want 1", k, a_valid_o); end
      g_cmp++; if (a_data_o !== 8'(121 + k)) begin g_err++; $display("FAIL bp_pop_data k%0d: got %0d want %0d", k, a_data_o, 121 + k); end
      tick();
    end
    #1;
    g_cmp++; if (a_valid_o !== 1'b0) begin g_err++; $display("FAIL bp_drained_valid: got %b want 0", a_valid_o); end
    g_cmp++; if (a_ready_o !== 1'b1) begin g_err++; $display("FAIL bp_ready_back: got %b want 1", a_ready_o); end
    g_cmp++; if (a_credits_o !== 2'd3) begin g_err++; $display("FAIL bp_credits_back: got %0d want 3", a_credits_o); end
    tick();
  endtask

  task automatic test_accept_and_pop();
    for (int c = 0; c < 5; c++) begin
      a_valid_i = (c == 0 || c == 2 || c == 4);
      a_data_i  = 8'(31 + c / 2);
      a_ready_i = (c == 4);
      #1;
      if (c == 4) begin
        g_cmp++; if (a_credits_o !== 2'd1) begin g_err++; $display("FAIL sim_credits_pre: got %0d want 1", a_credits_o); end
        g_cmp++; if (a_pipe_valid_o !== 1'b1) begin g_err++; $display("FAIL sim_accept: got %b want 1", a_pipe_valid_o); end
        g_cmp++; if (a_data_o !== 8'd131) begin g_err++; $display("FAIL sim_head_pre: got %0d want 131", a_data_o); end
      end
      tick();
    end
    a_valid_i = 1'b0;
    a_ready_i = 1'b0;
    #1;
    g_cmp++; if (a_credits_o !== 2'd1) begin g_err++; $display("FAIL sim_credits_post: got %0d want 1", a_credits_o); end
    g_cmp++; if (u_dut_a.r_count !== 2'd1) begin g_err++; $display("FAIL sim_count_post: got %0d want 1", u_dut_a.r_count); end
    g_cmp++; if (a_data_o !== 8'd132) begin g_err++; $display("FAIL sim_head_post: got %0d want 132", a_data_o); end
    tick();
    a_ready_i = 1'b1;
    repeat (5) tick();
    #1;
    g_cmp++; if (a_credits_o !== 2'd3) begin g_err++; $display("FAIL sim_credits_drain: got %0d want 3", a_credits_o); end
    tick();
  endtask

  task automatic test_latency0();
    int nxt;
    nxt = 1;
    for (int c = 0; c < 8; c++) begin
      logic even;
      even = (c % 2 == 0);
      b_ready_i = ~even;
      b_valid_i = 1'b1;
      b_data_i  = 8'(nxt);
      #1;
      g_cmp++; if (b_ready_o !== even) begin g_err++; $display("FAIL l0_ready c%0d: got %b want %b", c, b_ready_o, even); end
      g_cmp++; if (b_pipe_valid_o !== even) begin g_err++; $display("FAIL l0_accept c%0d: got %b want %b", c, b_pipe_valid_o, even); end
      g_cmp++; if (b_valid_o !== ~even) begin g_err++; $display("FAIL l0_valid c%0d: got %b want %b", c, b_valid_o, ~even); end
      if (!even) begin
        g_cmp++; if (b_data_o !== 8'(100 + (c + 1) / 2)) begin g_err++; $display("FAIL l0_data c%0d: got %0d want %0d", c, b_data_o, 100 + (c + 1) / 2); end
      end
      if (even) nxt++;
      tick();
    end
    b_valid_i = 1'b0;
    b_ready_i = 1'b0;
    #1;
    g_cmp++; if (b_credits_o !== 1'b1) begin g_err++; $display("FAIL l0_credits_end: got %0d want 1", b_credits_o); end
    tick();
  endtask

  task automatic test_reset_midflight();
    a_ready_i = 1'b0;
    for (int c = 0; c < 3; c++) begin
      a_valid_i = 1'b1;
      a_data_i  = 8'(41 + c);
      tick();
    end
    a_valid_i = 1'b0;
    #1;
    g_cmp++; if (a_valid_o !== 1'b1) begin g_err++; $display("FAIL rst_pre_valid: got %b want 1", a_valid_o); end
    g_cmp++; if (a_credits_o !== 2'd0) begin g_err++; $display("FAIL rst_pre_credits: got %0d want 0", a_credits_o); end
    rst_n = 1'b0;
    #1;
    g_cmp++; if (a_valid_o !== 1'b0) begin g_err++; $display("FAIL rst_valid: got %b want 0", a_valid_o); end
    g_cmp++; if (a_credits_o !== 2'd3) begin g_err++; $display("FAIL rst_credits: got %0d want 3", a_credits_o); end
    rst_n = 1'b1;
    tick();
    a_ready_i = 1'b1;
    for (int c = 0; c < 4; c++) begin
      #1;
      g_cmp++; if (a_valid_o !== 1'b0) begin g_err++; $display("FAIL rst_late_valid c%0d: got %b want 0", c, a_valid_o); end
      g_cmp++; if (a_credits_o !== 2'd3) begin g_err++; $display("FAIL rst_late_credits c%0d: got %0d want 3", c, a_credits_o); end
      tick();
    end
  endtask

  task automatic test_wrap();
    logic [63:0] pat;
    logic [7:0]  q[$];
    int          m_cred;
    int          sent;
    int          popped;
    logic        exp_rdy;
    logic        pop;
    pat    = 64'hF3A596C3E7B15D2F;
    m_cred = 3;
    sent   = 0;
    popped = 0;
    for (int c = 0; c < 120 && popped < 20; c++) begin
      a_valid_i = (sent < 20);
      a_data_i  = 8'(51 + sent);
      a_ready_i = (c < 64) ? pat[c] : 1'b1;
      #1;
      exp_rdy = (m_cred != 0);
      g_cmp++; if (a_ready_o !== exp_rdy) begin g_err++; $display("FAIL wrap_ready c%0d: got %b want %b", c, a_ready_o, exp_rdy); end
      g_cmp++; if (32'(a_credits_o) != m_cred) begin g_err++; $display("FAIL wrap_credits c%0d: got %0d want %0d", c, a_credits_o, m_cred); end
      g_cmp++;
      if (32'(a_credits_o) + 32'(u_dut_a.r_count) + 32'(u_dut_a.r_infl) != 3) begin
        g_err++; $display("FAIL wrap_invariant c%0d: got %0d want 3", c,
                          32'(a_credits_o) + 32'(u_dut_a.r_count) + 32'(u_dut_a.r_infl));
      end
      pop = a_valid_o && a_ready_i;
      if (pop) begin
        g_cmp++;
        if (q.size() == 0) begin
          g_err++; $display("FAIL wrap_spurious c%0d: got data %0d want none", c, a_data_o);
        end else if (a_data_o !== q[0]) begin
          g_err++; $display("FAIL wrap_data c%0d: got %0d want %0d", c, a_data_o, q[0]);
        end
        if (q.size() != 0) void'(q.pop_front());
        popped++;
      end
      if (a_valid_i && exp_rdy) begin
        q.push_back(8'(151 + sent));
        sent++;
        m_cred--;
      end
      if (pop) m_cred++;
      tick();
    end
    a_valid_i = 1'b0;
    a_ready_i = 1'b0;
    #1;
    g_cmp++; if (popped != 20) begin g_err++; $display("FAIL wrap_popped: got %0d want 20", popped); end
    g_cmp++; if (a_credits_o !== 2'd3) begin g_err++; $display("FAIL wrap_credits_end: got %0d want 3", a_credits_o); end
    g_cmp++; if (a_valid_o !== 1'b0) begin g_err++; $display("FAIL wrap_valid_end: got %b want 0", a_valid_o); end
    tick();
  endtask

  initial begin
    test_reset();
    test_full_throughput();
    test_depth3_rate();
    test_backpressure();
    test_accept_and_pop();
    test_latency0();
    test_reset_midflight();
    test_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", g_cmp, g_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish want finish before 200000");
    $fatal(1);
  end

endmodule
